// File: rtl/n_term_edge_capture.sv
// ---------------------------------------------------------------------------
// n_term_edge_capture
//   North-edge termination stage for the fabric's top row. The north-bound
//   edge wires are looped back south, either directly or through one
//   register. Snapshots of the edge vector are timestamped and buffered in a
//   small show-ahead FIFO, which a readout master drains with valid/ready.
//
//   Edge bit order: 0..11 = A0, B0, C0, D0, F0, G0, G1, H0, H1, I0, I1, I2
//
// Ports
//   UserCLK       fabric user clock
//   resetn        asynchronous active-low reset
//   from_N        north-bound edge wires
//   to_S          south-bound loopback wires
//   loop_reg_en   static config: 1 = registered loopback, 0 = combinational
//   cap_mode      0 = single-shot on trigger, 1 = change-detect while armed
//   cap_trig      trigger / arm toggle, sampled each edge
//   cap_valid     FIFO head valid
//   cap_ready     consumer accepts the head entry
//   cap_data      head snapshot data (0 when empty)
//   cap_ts        head snapshot timestamp (0 when empty)
//   cap_overflow  sticky flag: a push was dropped
//   ovf_clr       clears cap_overflow (a same-edge drop wins)
//   cap_count     current FIFO occupancy, 0..DEPTH
//
// Capture FSM
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | not armed; pushes only on cap_trig in single-shot mode
//   ST_ARMED | change-detect armed; pushes whenever from_N differs from s1
// ---------------------------------------------------------------------------
module n_term_edge_capture #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     UserCLK,
  input  logic                     resetn,
  input  logic [WIDTH-1:0]         from_N,
  output logic [WIDTH-1:0]         to_S,
  input  logic                     loop_reg_en,
  input  logic                     cap_mode,
  input  logic                     cap_trig,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic [WIDTH-1:0]         cap_data,
  output logic [CNT_W-1:0]         cap_ts,
  output logic                     cap_overflow,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   cap_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // Registered state
  logic [WIDTH-1:0] s1_q;
  logic [CNT_W-1:0] ts_q,      ts_d;
  state_t           state_q,   state_d;
  logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             ovf_q,     ovf_d;

  // FIFO storage; no reset needed because the outputs are masked by count_q
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [CNT_W-1:0] fifo_ts_q   [DEPTH];

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // -------------------------------------------------------------------------
  // Loopback
  // -------------------------------------------------------------------------
  assign to_S = loop_reg_en ? s1_q : from_N;

  // -------------------------------------------------------------------------
  // Capture decision and next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;

    if (!cap_mode) begin
      // Single-shot: every triggered edge captures; leaving change-detect
      // mode always disarms.
      push_req = cap_trig;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Arming edge itself never captures.
          if (cap_trig) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          // Compare against the previous edge's sample, so a one-cycle
          // glitch yields two captures. The disarm edge still captures.
          push_req = (from_N != s1_q);
          if (cap_trig) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    pop     = (count_q != '0) && cap_ready;
    // A pop on a full FIFO frees the slot the push lands in.
    push_ok = push_req && (!full || pop);
    drop    = push_req && full && !pop;

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    ts_d = ts_q + CNT_W'(1);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      s1_q     <= '0;
      ts_q     <= '0;
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q     <= from_N;
      ts_q     <= ts_d;
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge UserCLK) begin
    if (push_ok) begin
      fifo_data_q[wr_ptr_q] <= from_N;
      fifo_ts_q[wr_ptr_q]   <= ts_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all derived from registers only
  // -------------------------------------------------------------------------
  assign cap_valid    = (count_q != '0);
  assign cap_data     = cap_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign cap_ts       = cap_valid ? fifo_ts_q[rd_ptr_q]   : '0;
  assign cap_overflow = ovf_q;
  assign cap_count    = count_q;

endmodule
